// File: rtl/sq_wave_pkg.sv
// Shared types and constants for the multi-channel square-wave generator.
// Config fields are stored at a fixed maximum width; unused upper bits stay zero.
package sq_wave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Upper bound on CNT_W / BURST_W that a channel can be built with.
    localparam int CFG_CNT_W   = 32;
    localparam int CFG_BURST_W = 16;
    localparam int MAX_CH      = 16;

    typedef struct packed {
        logic [CFG_CNT_W-1:0]   period;
        logic [CFG_CNT_W-1:0]   high;
        logic [CFG_CNT_W-1:0]   phase;
        logic [CFG_BURST_W-1:0] burst;
    } cfg_t;

    localparam logic [CFG_CNT_W-1:0] MIN_PERIOD = CFG_CNT_W'(2);

    localparam cfg_t CFG_RESET = '{
        period: MIN_PERIOD,
        high:   '0,
        phase:  '0,
        burst:  '0
    };

    // Channel-select width, never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int CH_IDX_W = ch_idx_w(MAX_CH);

endpackage

// File: rtl/sq_wave_ch.sv
// One square-wave channel: double-buffered config, IDLE/PHASE/RUN/DONE FSM,
// period/phase/burst counters and registered outputs.
module sq_wave_ch
    import sq_wave_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               i_clk,
    input  logic               i_srst,
    input  logic               i_pll_lock,
    input  logic               i_cfg_we,
    input  logic [CNT_W-1:0]   i_cfg_period,
    input  logic [CNT_W-1:0]   i_cfg_high,
    input  logic [CNT_W-1:0]   i_cfg_phase,
    input  logic [BURST_W-1:0] i_cfg_burst,
    input  logic               i_ch_en,
    output logic               o_sq,
    output logic               o_busy,
    output logic               o_done
);

    typedef logic [CFG_CNT_W-1:0]   wide_t;
    typedef logic [CFG_BURST_W-1:0] wide_burst_t;

    state_t             r_state;
    state_t             w_state_next;
    cfg_t               r_shadow;
    cfg_t               r_active;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   r_pcnt;
    logic [CNT_W-1:0]   w_pcnt_next;
    logic [BURST_W-1:0] r_bcnt;
    logic [BURST_W-1:0] w_bcnt_next;
    logic               r_sq;
    logic               r_busy;
    logic               r_done;

    wide_t       w_period_eff;
    wide_t       w_high_eff;
    wide_t       w_cnt_wide;
    wide_t       w_pcnt_wide;
    wide_burst_t w_bcnt_inc;
    logic        w_wrap;
    logic        w_phase_end;
    logic        w_burst_end;
    logic        w_load;

    // Clamp the active config so RUN never sees a period below two cycles.
    assign w_period_eff = (r_active.period < MIN_PERIOD) ? MIN_PERIOD : r_active.period;
    assign w_high_eff   = (r_active.high > w_period_eff) ? w_period_eff : r_active.high;

    assign w_cnt_wide  = CFG_CNT_W'(r_cnt);
    assign w_pcnt_wide = CFG_CNT_W'(r_pcnt);
    assign w_bcnt_inc  = CFG_BURST_W'(r_bcnt) + CFG_BURST_W'(1);

    assign w_wrap      = (w_cnt_wide == (w_period_eff - wide_t'(1)));
    assign w_phase_end = (w_pcnt_wide == (r_active.phase - wide_t'(1)));
    assign w_burst_end = (r_active.burst != '0) && (w_bcnt_inc == r_active.burst);

    // Active config follows the shadow while idle and only at period boundaries in RUN.
    assign w_load = (r_state == IDLE) || ((r_state == RUN) && w_wrap);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pcnt_next  = r_pcnt;
        w_bcnt_next  = r_bcnt;
        if (!i_pll_lock) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_pcnt_next  = '0;
            w_bcnt_next  = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_ch_en) begin
                        w_cnt_next   = '0;
                        w_pcnt_next  = '0;
                        w_bcnt_next  = '0;
                        // Decide on the value being loaded into the active copy this edge.
                        w_state_next = (r_shadow.phase != '0) ? PHASE : RUN;
                    end
                end
                PHASE: begin
                    if (!i_ch_en) begin
                        w_state_next = IDLE;
                    end else if (w_phase_end) begin
                        w_state_next = RUN;
                        w_cnt_next   = '0;
                        w_bcnt_next  = '0;
                    end else begin
                        w_pcnt_next = r_pcnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (w_wrap) begin
                        w_cnt_next = '0;
                        if (r_active.burst != '0) begin
                            w_bcnt_next = r_bcnt + BURST_W'(1);
                        end
                        if (w_burst_end) begin
                            w_state_next = DONE;
                        end else if (!i_ch_en) begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!i_ch_en) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_pcnt   <= '0;
            r_bcnt   <= '0;
            r_shadow <= CFG_RESET;
            r_active <= CFG_RESET;
            r_sq     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pcnt  <= w_pcnt_next;
            r_bcnt  <= w_bcnt_next;
            if (i_cfg_we) begin
                r_shadow <= '{
                    period: CFG_CNT_W'(i_cfg_period),
                    high:   CFG_CNT_W'(i_cfg_high),
                    phase:  CFG_CNT_W'(i_cfg_phase),
                    burst:  CFG_BURST_W'(i_cfg_burst)
                };
            end
            if (w_load) begin
                r_active <= r_shadow;
            end
            // Outputs lag the state by one cycle, except lock loss clears them at once.
            r_sq   <= i_pll_lock && (r_state == RUN) && (w_cnt_wide < w_high_eff);
            r_busy <= i_pll_lock && ((r_state == PHASE) || (r_state == RUN));
            r_done <= i_pll_lock && (r_state == DONE);
        end
    end

    assign o_sq   = r_sq;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/sq_wave_gen.sv
// Multi-channel square-wave generator: decodes config writes to per-channel
// strobes and replicates sq_wave_ch once per channel.
module sq_wave_gen
    import sq_wave_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int CNT_W    = 16,
    parameter  int BURST_W  = 8,
    localparam int CH_SEL_W = ch_idx_w(NUM_CH)
) (
    input  logic                clkin,
    input  logic                reset,
    input  logic                pll_lock,
    input  logic                cfg_we,
    input  logic [CH_SEL_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [CNT_W-1:0]    cfg_phase,
    input  logic [BURST_W-1:0]  cfg_burst,
    input  logic [NUM_CH-1:0]   ch_en,
    output logic [NUM_CH-1:0]   sq_out,
    output logic [NUM_CH-1:0]   busy,
    output logic [NUM_CH-1:0]   done
);

    logic [NUM_CH-1:0] w_ch_we;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Selects at or beyond NUM_CH match no channel and are dropped.
            assign w_ch_we[gi] = cfg_we && (CH_IDX_W'(cfg_ch) == CH_IDX_W'(gi));

            sq_wave_ch #(
                .CNT_W   (CNT_W),
                .BURST_W (BURST_W)
            ) u_ch (
                .i_clk        (clkin),
                .i_srst       (reset),
                .i_pll_lock   (pll_lock),
                .i_cfg_we     (w_ch_we[gi]),
                .i_cfg_period (cfg_period),
                .i_cfg_high   (cfg_high),
                .i_cfg_phase  (cfg_phase),
                .i_cfg_burst  (cfg_burst),
                .i_ch_en      (ch_en[gi]),
                .o_sq         (sq_out[gi]),
                .o_busy       (busy[gi]),
                .o_done       (done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sq_wave_gen.sv
// Scoreboard bench for sq_wave_gen: stimulus queues per-cycle expected
// {sq_out, busy, done} per channel; a negedge monitor pops and compares.
module tb_sq_wave_gen;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic               clkin = 1'b0;
    logic               reset;
    logic               pll_lock;
    logic               cfg_we;
    logic [1:0]         cfg_ch;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_high;
    logic [CNT_W-1:0]   cfg_phase;
    logic [BURST_W-1:0] cfg_burst;
    logic [NUM_CH-1:0]  ch_en;
    logic [NUM_CH-1:0]  sq_out;
    logic [NUM_CH-1:0]  busy;
    logic [NUM_CH-1:0]  done;

    typedef struct {
        int         cyc;
        int         ch;
        logic [2:0] want;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   n;
    int   base;
    int   t;

    sq_wave_gen #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_phase  (cfg_phase),
        .cfg_burst  (cfg_burst),
        .ch_en      (ch_en),
        .sq_out     (sq_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clkin = ~clkin;

    always @(posedge clkin) cyc <= cyc + 1;

    // Monitor: every entry due this cycle is compared; overdue entries count as failures.
    always @(negedge clkin) begin
        int         i;
        logic [2:0] got;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                got = {sq_out[sb[i].ch], busy[sb[i].ch], done[sb[i].ch]};
                total++;
                if (sb[i].cyc < cyc) begin
                    bad++;
                    $display("FAIL %s stale entry for cyc=%0d ch=%0d at cyc=%0d", sb[i].name, sb[i].cyc, sb[i].ch, cyc);
                end else if (got !== sb[i].want) begin
                    bad++;
                    $display("FAIL %s cyc=%0d ch=%0d got sq/busy/done=%b required=%b",
                             sb[i].name, cyc, sb[i].ch, got, sb[i].want);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic expect_run(input int start, input int len, input int ch,
                              input logic sq, input logic bz, input logic dn, input string name);
        for (int k = 0; k < len; k++) begin
            exp_t e;
            e.cyc  = start + k;
            e.ch   = ch;
            e.want = {sq, bz, dn};
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic cfg_write(input int ch, input int per, input int hi, input int ph, input int bu);
        cfg_we     = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = CNT_W'(per);
        cfg_high   = CNT_W'(hi);
        cfg_phase  = CNT_W'(ph);
        cfg_burst  = BURST_W'(bu);
        tick();
        cfg_we = 1'b0;
        $display("cfg cyc=%0d ch=%0d period=%0d high=%0d phase=%0d burst=%0d", cyc, ch, per, hi, ph, bu);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        pll_lock   = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_phase  = '0;
        cfg_burst  = '0;
        ch_en      = '0;
        tick();
        tick();
        tick();
        for (int c = 0; c < NUM_CH; c++) expect_run(cyc + 1, 2, c, 1'b0, 1'b0, 1'b0, "reset_state");
        reset    = 1'b0;
        pll_lock = 1'b1;

        // Continuous 10/3 wave on ch0, then a mid-period high change, then ch_en drop at cnt=1.
        cfg_write(0, 10, 3, 0, 0);
        tick();
        n    = cyc;
        base = n + 2;
        expect_run(base - 1, 1, 0, 1'b0, 1'b0, 1'b0, "a_latency");
        for (int k = 0; k < 3; k++) begin
            expect_run(base + 10 * k,     3, 0, 1'b1, 1'b1, 1'b0, "a_high");
            expect_run(base + 10 * k + 3, 7, 0, 1'b0, 1'b1, 1'b0, "a_low");
        end
        for (int k = 3; k < 6; k++) begin
            expect_run(base + 10 * k,     8, 0, 1'b1, 1'b1, 1'b0, "c_new_high");
            expect_run(base + 10 * k + 8, 2, 0, 1'b0, 1'b1, 1'b0, "c_new_low");
        end
        expect_run(base + 60, 3, 0, 1'b0, 1'b0, 1'b0, "d_idle");
        ch_en[0] = 1'b1;
        wait_cyc(base + 22);
        cfg_write(0, 10, 8, 0, 0);
        wait_cyc(base + 50);
        ch_en[0] = 1'b0;
        wait_cyc(base + 63);

        // Phase-delayed burst of three 4/2 periods on ch1.
        cfg_write(1, 4, 2, 5, 3);
        tick();
        n = cyc;
        t = n + 1;
        expect_run(t,     1, 1, 1'b0, 1'b0, 1'b0, "b_pre");
        expect_run(t + 1, 5, 1, 1'b0, 1'b1, 1'b0, "b_phase");
        for (int k = 0; k < 3; k++) begin
            expect_run(t + 6 + 4 * k, 2, 1, 1'b1, 1'b1, 1'b0, "b_pulse_high");
            expect_run(t + 8 + 4 * k, 2, 1, 1'b0, 1'b1, 1'b0, "b_pulse_low");
        end
        expect_run(t + 18, 7, 1, 1'b0, 1'b0, 1'b1, "b_done_hold");
        expect_run(t + 25, 2, 1, 1'b0, 1'b0, 1'b0, "b_done_clear");
        ch_en[1] = 1'b1;
        wait_cyc(t + 23);
        ch_en[1] = 1'b0;
        wait_cyc(t + 27);

        // Lock loss with ch0 and ch2 running, then restart from cnt=0.
        cfg_write(0, 6, 3, 0, 0);
        cfg_write(2, 5, 2, 0, 0);
        tick();
        n    = cyc;
        base = n + 2;
        expect_run(base,      3, 0, 1'b1, 1'b1, 1'b0, "e_ch0_high");
        expect_run(base + 3,  3, 0, 1'b0, 1'b1, 1'b0, "e_ch0_low");
        expect_run(base + 6,  2, 0, 1'b1, 1'b1, 1'b0, "e_ch0_high2");
        expect_run(base,      2, 2, 1'b1, 1'b1, 1'b0, "e_ch2_high");
        expect_run(base + 2,  3, 2, 1'b0, 1'b1, 1'b0, "e_ch2_low");
        expect_run(base + 5,  2, 2, 1'b1, 1'b1, 1'b0, "e_ch2_high2");
        expect_run(base + 7,  1, 2, 1'b0, 1'b1, 1'b0, "e_ch2_low2");
        expect_run(base + 8,  4, 0, 1'b0, 1'b0, 1'b0, "e_lock_lost");
        expect_run(base + 8,  4, 2, 1'b0, 1'b0, 1'b0, "e_lock_lost");
        expect_run(base + 12, 3, 0, 1'b1, 1'b1, 1'b0, "e_ch0_restart_high");
        expect_run(base + 15, 3, 0, 1'b0, 1'b1, 1'b0, "e_ch0_restart_low");
        expect_run(base + 12, 2, 2, 1'b1, 1'b1, 1'b0, "e_ch2_restart_high");
        expect_run(base + 14, 3, 2, 1'b0, 1'b1, 1'b0, "e_ch2_restart_low");
        ch_en = 3'b101;
        wait_cyc(base + 7);
        pll_lock = 1'b0;
        wait_cyc(base + 10);
        pll_lock = 1'b1;
        wait_cyc(base + 17);
        ch_en = '0;
        wait_cyc(base + 35);

        // Clamps: period 0 acts as 2, high > period is constant high, high 0 is constant low.
        cfg_write(0, 0, 1, 0, 0);
        cfg_write(1, 10, 20, 0, 0);
        cfg_write(2, 4, 0, 0, 0);
        tick();
        n    = cyc;
        base = n + 2;
        for (int c = 0; c < NUM_CH; c++) expect_run(base - 1, 1, c, 1'b0, 1'b0, 1'b0, "f_pre");
        for (int k = 0; k < 24; k++) expect_run(base + k, 1, 0, (k % 2 == 0), 1'b1, 1'b0, "f_period0");
        expect_run(base, 24, 1, 1'b1, 1'b1, 1'b0, "f_high_clamp");
        expect_run(base, 24, 2, 1'b0, 1'b1, 1'b0, "f_high0");
        ch_en = 3'b111;
        tick();
        // Out-of-range channel select must not disturb any running channel.
        cfg_write(3, 7, 0, 0, 0);
        wait_cyc(base + 24);
        ch_en = '0;
        wait_cyc(base + 40);

        // Reset mid-burst, then confirm the configs were cleared to period 2 / high 0.
        cfg_write(1, 4, 2, 0, 5);
        tick();
        n    = cyc;
        base = n + 2;
        expect_run(base,     2, 1, 1'b1, 1'b1, 1'b0, "g_burst_high");
        expect_run(base + 2, 2, 1, 1'b0, 1'b1, 1'b0, "g_burst_low");
        expect_run(base + 4, 2, 1, 1'b1, 1'b1, 1'b0, "g_burst_high2");
        for (int c = 0; c < NUM_CH; c++) expect_run(base + 6, 3, c, 1'b0, 1'b0, 1'b0, "g_reset");
        expect_run(base + 10, 4, 0, 1'b0, 1'b1, 1'b0, "g_cleared_cfg");
        expect_run(base + 10, 4, 1, 1'b0, 1'b1, 1'b0, "g_cleared_cfg");
        ch_en = 3'b010;
        wait_cyc(base + 5);
        reset = 1'b1;
        ch_en = '0;
        wait_cyc(base + 6);
        reset = 1'b0;
        wait_cyc(base + 8);
        ch_en = 3'b011;
        wait_cyc(base + 16);

        if (sb.size() != 0) begin
            total += sb.size();
            bad   += sb.size();
            $display("FAIL leftover_entries count=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sq_wave_gen.md
Name: sq_wave_gen

Overview:
Parametrised multi-channel square-wave generator, clocked from the on-chip PLL output. Each channel has a programmable period, high time, start phase and burst count. Configuration is double-buffered so changes take effect glitch-free at a period boundary. All channels are held off until the PLL reports lock, and stop cleanly at the end of a period.

Parameters:
NUM_CH, 4, number of independent output channels (1..16)
CNT_W, 16, width of the period, high and phase counters
BURST_W, 8, width of the burst-count field; 0 means continuous

Ports:
clkin  input  1  system clock (PLL output domain)
reset  input  1  synchronous, active-high reset
pll_lock  input  1  PLL lock status; low forces every channel idle
cfg_we  input  1  single-cycle configuration write strobe
cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel of the write
cfg_period  input  CNT_W  period in clkin cycles
cfg_high  input  CNT_W  high time in clkin cycles
cfg_phase  input  CNT_W  delay from start to first rising edge
cfg_burst  input  BURST_W  number of periods to emit; 0 = continuous
ch_en  input  NUM_CH  per-channel run enable (level)
sq_out  output  NUM_CH  registered square-wave outputs
busy  output  NUM_CH  channel is in PHASE or RUN
done  output  NUM_CH  burst completed, held until ch_en drops

Behaviour:
- Clocking and reset: single clock clkin. reset is synchronous, active-high. On reset: sq_out=0, busy=0, done=0, all states IDLE, all counters 0, shadow and active configs cleared (period 2, high 0, phase 0, burst 0).
- Config write: when cfg_we=1, the fields are captured into the cfg_ch shadow register in the same edge. cfg_ch >= NUM_CH is ignored.
- Shadow to active copy happens in two cases:
  - in IDLE, every cycle;
  - in RUN, on the last cycle of a period (cnt == period_eff-1).
  - PHASE never reloads.
- Clamping: period_eff = max(period, 2); high_eff = min(high, period_eff). high_eff=0 gives a constant low output; high_eff=period_eff gives a constant high output.
- Per-channel FSM:
  - IDLE -> PHASE when ch_en & pll_lock & phase != 0; pcnt=0.
  - IDLE -> RUN when ch_en & pll_lock & phase == 0; cnt=0, bcnt=0.
  - PHASE: pcnt increments; at pcnt == phase-1 -> RUN with cnt=0.
  - RUN: cnt increments and wraps to 0 after period_eff-1. On each wrap, bcnt increments.
  - Stop when burst != 0 and bcnt reaches burst at wrap: -> DONE.
  - Stop when ch_en drops during RUN: the current period is finished, then -> IDLE at wrap.
  - ch_en drop during PHASE: -> IDLE immediately.
  - DONE: done=1, sq_out=0; -> IDLE when ch_en == 0.
- Lock loss: pll_lock == 0 in any state -> IDLE on the next edge with sq_out=0. This does not wait for the period boundary. A channel with ch_en still high restarts from PHASE/RUN once lock returns.
- Output: sq_out registered; sq_out=1 in exactly the cycles where state==RUN && cnt < high_eff.
- Latency: ch_en rising sampled at edge t (phase 0) -> first sq_out=1 visible after edge t+1. With phase P, the first high appears P cycles later.
- busy is registered and tracks the state with the same timing as sq_out.
- Simultaneous events:
  - cfg_we to a channel on its wrap cycle: the write lands in shadow; the active copy loads the old shadow value, and the new value applies at the next wrap.
  - ch_en drop and burst completion on the same wrap: DONE takes priority.
  - reset overrides everything.
- Counter widths: cnt, pcnt are CNT_W; bcnt is BURST_W. No overflow is possible given the clamps.

Decomposition:
- sq_wave_pkg holds:
  - the state enum (IDLE, PHASE, RUN, DONE);
  - a cfg struct {period, high, phase, burst};
  - constants MIN_PERIOD=2 and CH_IDX_W.
- Sub-module sq_wave_ch holds one channel: shadow/active config, FSM, counters and output register. sq_wave_gen decodes cfg_ch into per-channel write enables and instantiates NUM_CH copies in a generate loop.

Test Plan:
- Reset, then write ch0 period=10 high=3 phase=0 burst=0, ch_en[0]=1, pll_lock=1 -> sq_out[0] high 3 cycles, low 7, repeating. The first high appears 1 cycle after ch_en is sampled.
- ch1 period=4 high=2 phase=5 burst=3 -> 5 idle cycles, then exactly 3 pulses of 2 cycles each. done[1]=1 after the 12th RUN cycle and stays set until ch_en[1]=0.
- ch0 running period=10 high=3; write high=8 mid-period -> the current period keeps a 3-cycle high, and the next period shows an 8-cycle high with no runt pulse.
- Drop ch_en[0] at cnt=1 -> the remaining high cycle and the low cycles of that period complete, then IDLE with busy=0.
- Drop pll_lock while two channels run -> both sq_out=0 on the next edge. Reassert lock -> both restart from cnt=0.
- Edge cases: period=0 behaves as 2; high=20 with period=10 gives constant 1; high=0 gives constant 0 while busy=1; cfg_ch=NUM_CH write is ignored; reset asserted mid-burst gives all outputs 0 on the next edge.
